exec_muldiv_unit: RTL and testbench
===================================

Name: exec_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage of the 6-stage core.
- Consumes operands and destination register from the ID/EX pipeline register (32-bit operand fields, 5-bit rd field).
- Holds the front of the pipeline with a stall request while it works, and returns a registered result plus rd to the EX/MEM stage.
- Honours the same flush (clear) as the pipeline registers around it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous flush, aborts any operation
- start  input  1  issue request; operands valid this cycle
- funct3  input  3  RV32M operation select
- src_a  input  32  rs1 value
- src_b  input  32  rs2 value
- rd_in  input  5  destination register
- busy  output  1  operation in progress (registered)
- stall_req  output  1  start | busy, combinational, to the hazard unit
- done  output  1  one-cycle result-valid pulse
- result  output  32  registered result, held until the next done
- rd_out  output  5  rd captured at start, held with result

Behaviour:
- Reset: busy=0, done=0, result=0, rd_out=0, state=IDLE, counter=0. Takes effect immediately and aborts any operation.
- States:
  - IDLE -> CALC on start & ~clear & ~busy.
  - IDLE -> FIN on start when the special case below is detected.
  - CALC -> FIN when counter reaches ITERS-1.
  - FIN -> IDLE unconditionally.
- Capture at start:
  - Operand magnitudes, result-negate flag, and funct3 class (high/low word, quotient/remainder).
  - rd_in is latched to rd_out in the same cycle.
- MUL/MULH/MULHSU/MULHU: radix-2 shift-add on magnitudes into a 64-bit accumulator, one multiplier bit per cycle.
  - Signedness per funct3: MULHSU treats only src_a as signed.
  - The final product is negated if the signs differ.
  - MUL returns bits [31:0]; MULH* return bits [63:32].
- DIV/DIVU/REM/REMU: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
- Special cases (single cycle, no CALC):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = src_a.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Latency, with start sampled at edge 0:
  - Normal operation: busy=1 after edge 1; result and done=1 visible after edge 33; busy=0 after edge 33.
  - Special case: done after edge 1.
- done is high for exactly one cycle; result and rd_out are updated only in that same cycle.
- start while busy is ignored.
- Clear:
  - clear has priority over start.
  - clear in any state: next edge forces IDLE, busy=0, done=0; result and rd_out keep their old values; no done pulse is ever produced for the aborted op.
  - A new start may be accepted on the cycle after clear.
- Only src_a, src_b, funct3 and rd_in at the start edge matter; input changes during CALC are ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply jumps CALC -> FIN as soon as the remaining unprocessed multiplier bits are all zero. Latency is then 2 + index of the highest set bit of |multiplier|, minimum 2 cycles. For a zero multiplier, done appears after edge 2. Divide latency is unchanged.
- Undefined: every multiply takes the fixed 33-cycle latency.

Decomposition:
- Package muldiv_pkg:
  - XLEN.
  - funct3 enum: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State enum {IDLE, CALC, FIN}.
  - Counter width $clog2(ITERS).
- Sub-module muldiv_operand_prep (combinational): produces magnitudes, negate flags, and the divide-by-zero/overflow detect from funct3, src_a and src_b.

Test Plan:
- MUL 7 x 0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, done after edge 33, stall_req high from the start cycle to the done cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 100 / 0xFFFFFFF9 -> 0xFFFFFFF2; REM with the same operands -> 0x00000002; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each gives done after edge 1.
- DIV issued, clear at edge 10 -> busy=0 after edge 10, no done pulse, result unchanged; new MUL started at edge 11 -> done after edge 44.
- reset asserted mid-CALC -> busy, done, result and rd_out all 0 immediately; a start while busy is ignored. With MULDIV_EARLY_OUT_EN, MUL 3 x 1 -> done after edge 2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative RV32M multiply/divide unit.
// Optional multiply early-out is enabled by defining MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand magnitudes, result sign and divide special-case detection.
// Purely combinational; evaluated on the issue cycle only.
module muldiv_operand_prep
    import muldiv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg,
    output logic            div_zero,
    output logic            div_ovf
);

    logic sa_en;
    logic sb_en;
    logic sa;
    logic sb;
    logic is_div;
    logic is_rem;

    always_comb begin
        sa_en = 1'b1;
        sb_en = 1'b1;
        unique case (1'b1)
            funct3 == MULHSU: sb_en = 1'b0;
            funct3 == MULHU,
            funct3 == DIVU,
            funct3 == REMU: begin
                sa_en = 1'b0;
                sb_en = 1'b0;
            end
            default: ;
        endcase
    end

    assign is_div = funct3[2];
    assign is_rem = funct3[2] & funct3[1];
    assign sa     = sa_en & src_a[XLEN-1];
    assign sb     = sb_en & src_b[XLEN-1];
    assign mag_a  = sa ? -src_a : src_a;
    assign mag_b  = sb ? -src_b : src_b;

    // Remainder follows the dividend's sign only.
    assign neg = is_rem ? sa : (sa ^ sb);

    assign div_zero = is_div & (src_b == '0);
    assign div_ovf  = is_div & ~funct3[0]
                    & (src_a == {1'b1, {(XLEN-1){1'b0}}})
                    & (src_b == '1);

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish on a zero tail.
module exec_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int W2 = 2 * XLEN;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [W2-1:0]    acc_nx;
    logic [W2-1:0]    prod;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [XLEN-1:0]  spec_val;
    logic [XLEN-1:0]  quo_v;
    logic [XLEN-1:0]  rem_v;
    logic [XLEN-1:0]  fin_val;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;
    logic             neg;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic             is_rem;
    logic             neg_q;
    logic             cls_div;
    logic             cls_hi;
    logic             cls_rem;
    logic             spec_q;
    logic             early;
    logic             last;
    logic [4:0]       rd_q;

    muldiv_operand_prep u_prep (
        .funct3   (funct3),
        .src_a    (src_a),
        .src_b    (src_b),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .neg      (neg),
        .div_zero (div_zero),
        .div_ovf  (div_ovf)
    );

    assign stall_req = start | busy;
    assign special   = div_zero | div_ovf;
    assign is_rem    = funct3[2] & funct3[1];

    always_comb begin
        spec_val = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        if (div_zero)
            spec_val = is_rem ? src_a : '1;
    end

    // Divide keeps {remainder, dividend/quotient} in acc.
    always_comb begin
        rem_sh = {acc[W2-1:XLEN], acc[XLEN-1]};
        diff   = rem_sh - {1'b0, mcand[XLEN-1:0]};
        acc_nx = acc + (mplier[0] ? mcand : '0);
        if (cls_div)
            acc_nx = diff[XLEN]
                   ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                   : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    assign prod  = neg_q ? -acc : acc;
    assign quo_v = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_v = neg_q ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];

    always_comb begin
        fin_val = cls_hi ? prod[W2-1:XLEN] : prod[XLEN-1:0];
        if (cls_div)
            fin_val = cls_rem ? rem_v : quo_v;
        if (spec_q)
            fin_val = acc[XLEN-1:0];
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early = ~cls_div & ~|mplier[XLEN-1:1];
`else
    assign early = 1'b0;
`endif

    assign last = (cnt == CNT_W'(ITERS - 1)) | early;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            rd_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg_q   <= 1'b0;
            cls_div <= 1'b0;
            cls_hi  <= 1'b0;
            cls_rem <= 1'b0;
            spec_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !busy) begin
                            busy    <= 1'b1;
                            rd_q    <= rd_in;
                            neg_q   <= neg;
                            cls_div <= funct3[2];
                            cls_hi  <= ~funct3[2] & |funct3[1:0];
                            cls_rem <= is_rem;
                            spec_q  <= special;
                            cnt     <= '0;
                            mplier  <= mag_b;
                            mcand   <= {{XLEN{1'b0}},
                                        funct3[2] ? mag_b : mag_a};
                            if (special) begin
                                state <= FIN;
                                acc   <= {{XLEN{1'b0}}, spec_val};
                            end else begin
                                state <= CALC;
                                acc   <= funct3[2]
                                       ? {{XLEN{1'b0}}, mag_a}
                                       : '0;
                            end
                        end
                    end
                    CALC: begin
                        acc    <= acc_nx;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (!cls_div)
                            mcand <= mcand << 1;
                        if (last)
                            state <= FIN;
                    end
                    FIN: begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= fin_val;
                        rd_out <= rd_q;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit; honours MULDIV_EARLY_OUT_EN.
module tb_exec_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        clear;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int fails  = 0;

    exec_muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .funct3    (funct3),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    // Expected done edge for a multiply given |multiplier|.
    function automatic int mul_lat(input logic [31:0] m);
        int hb;
        hb = -1;
        for (int i = 0; i < 32; i++)
            if (m[i]) hb = i;
        if (!EARLY) return 33;
        if (hb < 0) return 2;
        return hb + 2;
    endfunction

    task automatic run_op(input string       tag,
                          input logic [2:0]  f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0]  r,
                          input logic [31:0] exp,
                          input int          lat,
                          input bit          poke);
        int got;
        bit st_ok;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        src_a  = a;
        src_b  = b;
        rd_in  = r;
        #1;
        st_ok = (stall_req === 1'b1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        src_a  = $urandom;
        src_b  = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
        got = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                got = n;
                break;
            end
            if (stall_req !== 1'b1) st_ok = 1'b0;
            if (poke && n == 3) begin
                start  = 1'b1;
                funct3 = DIVU;
                src_a  = 32'd1;
                src_b  = 32'd0;
                rd_in  = r + 5'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " lat"}, got, lat);
        check({tag, " res"}, result, exp);
        check({tag, " rd"}, {27'b0, rd_out}, {27'b0, r});
        check({tag, " stall"}, {31'b0, st_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, " pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        bit seen;
        int dn;
        reset  = 1'b1;
        clear  = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        src_a  = '0;
        src_b  = '0;
        rd_in  = '0;
        #2;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst stall", {31'b0, stall_req}, 32'd0);
        check("rst res", result, 32'd0);
        check("rst rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5,
               32'hFFFF_FFEB, mul_lat(32'd3), 1'b0);
        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFE, mul_lat(32'hFFFF_FFFF), 1'b1);
        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
               32'h0, mul_lat(32'd1), 1'b0);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8,
               32'hFFFF_FFFF, mul_lat(32'd2), 1'b0);
        run_op("div", DIV, 32'd100, 32'hFFFF_FFF9, 5'd9,
               32'hFFFF_FFF2, 33, 1'b0);
        run_op("rem", REM, 32'd100, 32'hFFFF_FFF9, 5'd10,
               32'd2, 33, 1'b0);
        run_op("divu", DIVU, 32'd100, 32'd7, 5'd11,
               32'd14, 33, 1'b1);
        run_op("remu", REMU, 32'd100, 32'd7, 5'd12,
               32'd2, 33, 1'b0);
        run_op("divu0", DIVU, 32'd5, 32'd0, 5'd13,
               32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem0", REM, 32'd5, 32'd0, 5'd14,
               32'd5, 1, 1'b0);
        run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
               32'h8000_0000, 1, 1'b0);
        run_op("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
               32'h0, 1, 1'b0);

        // Abort a divide with clear at edge 10.
        @(negedge clk);
        start  = 1'b1;
        funct3 = DIV;
        src_a  = 32'd100;
        src_b  = 32'd7;
        rd_in  = 5'd17;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
            if (n == 1) check("clr busy1", {31'b0, busy}, 32'd1);
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr busy", {31'b0, busy}, 32'd0);
        check("clr done", {31'b0, done | seen}, 32'd0);
        check("clr res", result, 32'h0);
        check("clr rd", {27'b0, rd_out}, 32'd16);
        run_op("clr mulhu", MULHU, 32'h0001_0000, 32'h0001_0000, 5'd18,
               32'd1, mul_lat(32'h0001_0000), 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start  = 1'b1;
        funct3 = MUL;
        src_a  = 32'd3;
        src_b  = 32'h8000_0000;
        rd_in  = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar busy", {31'b0, busy}, 32'd0);
        check("ar done", {31'b0, done}, 32'd0);
        check("ar res", result, 32'd0);
        check("ar rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        check("ar nodone", dn, 32'd0);

        run_op("early", MUL, 32'd3, 32'd1, 5'd21,
               32'd3, mul_lat(32'd1), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
